// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg
// Shared definitions for the count monitor: FSM state encoding, error codes,
// stall counter width and a saturating increment helper. Imported by the RTL
// and by the testbench so both agree on encodings.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SKIP    = 2'b01,
        ERR_STALL   = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_code_t;

    // Wide enough for the largest legal stall limit (15).
    localparam int STALL_CNT_W = 4;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/count_monitor_stall.sv
// stall_timer
// Counts consecutive unchanged samples while the monitor is running.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   inc  - count one more unchanged sample
//   clr  - restart the count at zero (wins over inc)
//   hit  - the next inc reaches STALL_LIMIT
module stall_timer
    import count_monitor_pkg::*;
#(
    parameter int STALL_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [STALL_CNT_W-1:0] LIMIT_M1 = STALL_CNT_W'(STALL_LIMIT - 1);

    logic [STALL_CNT_W-1:0] cnt_q;
    logic [STALL_CNT_W-1:0] cnt_d;

    // hit looks one sample ahead and does not depend on inc, so the FSM can
    // use it in the same cycle it decides to increment without forming a loop.
    assign hit = (cnt_q == LIMIT_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {STALL_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor
// Watches an upstream counter and checks that it walks START..STOP in +1
// steps, flagging skips, stalls and overruns.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   count[7:0]    - upstream counter value, sampled every edge
//   enable        - 1 = checking active, 0 = freeze checks in RUN
//   clear         - synchronous return to IDLE, clears error/done
//   running       - in RUN
//   done          - in DONE
//   done_pulse    - one cycle on entry to DONE
//   error         - in ERROR
//   err_code[1:0] - reason for ERROR, held while in ERROR
//   steps[7:0]    - valid +1 increments seen in RUN, saturating
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter logic [7:0] START       = 8'd5,
    parameter logic [7:0] STOP        = 8'd67,
    parameter int         STALL_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic       enable,
    input  logic       clear,
    output logic       running,
    output logic       done,
    output logic       done_pulse,
    output logic       error,
    output logic [1:0] err_code,
    output logic [7:0] steps
);

    state_t    state_q, state_d;
    err_code_t err_q, err_d;
    logic [7:0] count_q;
    logic [7:0] steps_q, steps_d;
    logic running_q, running_d;
    logic done_q, done_d;
    logic done_pulse_q, done_pulse_d;
    logic error_q, error_d;
    logic stall_inc, stall_clr, stall_hit;
    logic is_step;

    stall_timer #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall (
        .clk(clk),
        .rst(rst),
        .inc(stall_inc),
        .clr(stall_clr),
        .hit(stall_hit)
    );

    // Compared at 9 bits so count_q == 255 can never be followed by a valid step.
    assign is_step = ({1'b0, count} == ({1'b0, count_q} + 9'd1));

    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        err_d     = err_q;
        stall_inc = 1'b0;
        stall_clr = 1'b0;

        if (clear) begin
            state_d   = ST_IDLE;
            steps_d   = '0;
            err_d     = ERR_NONE;
            stall_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && (count == START)) begin
                        steps_d   = '0;
                        stall_clr = 1'b1;
                        state_d   = (START == STOP) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (count > STOP) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_OVERRUN;
                        end else if (is_step) begin
                            steps_d   = sat_inc8(steps_q);
                            stall_clr = 1'b1;
                            if (count == STOP) begin
                                state_d = ST_DONE;
                            end
                        end else if (count == count_q) begin
                            stall_inc = 1'b1;
                            if (stall_hit) begin
                                state_d = ST_ERROR;
                                err_d   = ERR_STALL;
                            end
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = ERR_SKIP;
                        end
                    end
                end
                ST_DONE: begin
                    if (count != STOP) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_OVERRUN;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Flags are decoded from the next state so they change on the
        // same edge as the transition.
        running_d    = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        error_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            count_q      <= '0;
            steps_q      <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            count_q      <= count;
            steps_q      <= steps_d;
            running_q    <= running_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
            error_q      <= error_d;
        end
    end

    assign running    = running_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign error      = error_q;
    assign err_code   = err_q;
    assign steps      = steps_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
// Scoreboard bench for count_monitor. Each applied vector pushes the outputs
// expected after the next clock edge; a monitor pops and compares them just
// after that edge. A second instance with START == STOP covers the direct
// IDLE -> DONE path.
module tb_count_monitor;
    import count_monitor_pkg::*;

    typedef struct packed {
        logic       running;
        logic       done;
        logic       done_pulse;
        logic       error;
        logic [1:0] err_code;
        logic [7:0] steps;
    } obs_t;

    typedef struct packed {
        logic sel;
        obs_t exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [7:0] count;

    logic       running_a, done_a, pulse_a, error_a;
    logic [1:0] code_a;
    logic [7:0] steps_a;
    logic       running_b, done_b, pulse_b, error_b;
    logic [1:0] code_b;
    logic [7:0] steps_b;

    obs_t  obs_a, obs_b, mon_o;
    sb_t   sbq[$];
    string tagq[$];
    sb_t   mon_e;
    string mon_t;

    int vectors     = 0;
    int miscompares = 0;

    localparam obs_t IDLE0 = '0;

    count_monitor u_dut (
        .clk(clk), .rst(rst), .count(count), .enable(enable), .clear(clear),
        .running(running_a), .done(done_a), .done_pulse(pulse_a),
        .error(error_a), .err_code(code_a), .steps(steps_a)
    );

    count_monitor #(
        .START(8'd9), .STOP(8'd9), .STALL_LIMIT(4)
    ) u_dut_eq (
        .clk(clk), .rst(rst), .count(count), .enable(enable), .clear(clear),
        .running(running_b), .done(done_b), .done_pulse(pulse_b),
        .error(error_b), .err_code(code_b), .steps(steps_b)
    );

    assign obs_a = {running_a, done_a, pulse_a, error_a, code_a, steps_a};
    assign obs_b = {running_b, done_b, pulse_b, error_b, code_b, steps_b};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    function automatic obs_t mk(input int r, input int d, input int p,
                                input int e, input int c, input int s);
        obs_t o;
        o.running    = 1'(r);
        o.done       = 1'(d);
        o.done_pulse = 1'(p);
        o.error      = 1'(e);
        o.err_code   = 2'(c);
        o.steps      = 8'(s);
        return o;
    endfunction

    task automatic checkOutput(input string tag, input obs_t observed, input obs_t expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got run=%0b done=%0b pulse=%0b err=%0b code=%02b steps=%0d, required run=%0b done=%0b pulse=%0b err=%0b code=%02b steps=%0d",
                     tag, observed.running, observed.done, observed.done_pulse,
                     observed.error, observed.err_code, observed.steps,
                     expected.running, expected.done, expected.done_pulse,
                     expected.error, expected.err_code, expected.steps);
        end
    endtask

    // Drive one vector on the falling edge and queue what should appear
    // after the following rising edge.
    task automatic applyStimulus(input string tag, input int cnt, input int en,
                                 input int clr, input int rs, input int sel,
                                 input obs_t exp);
        sb_t e;
        @(negedge clk);
        count  = 8'(cnt);
        enable = 1'(en);
        clear  = 1'(clr);
        rst    = 1'(rs);
        e.sel  = 1'(sel);
        e.exp  = exp;
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    // Clean run from 'from' to 'to' (to < STOP); steps equals value - START.
    task automatic runSeq(input string tag, input int from, input int to);
        for (int v = from; v <= to; v++) begin
            applyStimulus(tag, v, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, v - 5));
        end
    endtask

    task automatic doClear(input string tag);
        applyStimulus(tag, 0, 1, 1, 0, 0, IDLE0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            mon_t = tagq.pop_front();
            mon_o = mon_e.sel ? obs_b : obs_a;
            checkOutput(mon_t, mon_o, mon_e.exp);
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        count  = 8'd0;

        applyStimulus("reset", 0, 0, 0, 1, 0, IDLE0);
        applyStimulus("reset", 0, 0, 0, 1, 0, IDLE0);
        applyStimulus("idle_disabled", 5, 0, 0, 0, 0, IDLE0);
        applyStimulus("idle_wait", 7, 1, 0, 0, 0, IDLE0);

        // Clean sequence, DONE hold, then overrun from DONE.
        runSeq("clean", 5, 66);
        applyStimulus("clean_done", 67, 1, 0, 0, 0, mk(0, 1, 1, 0, 0, 62));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("done_hold", 67, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 62));
        end
        applyStimulus("done_hold_disabled", 67, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 62));
        applyStimulus("done_overrun", 68, 1, 0, 0, 0, mk(0, 0, 0, 1, 3, 62));
        applyStimulus("overrun_sticky", 5, 1, 0, 0, 0, mk(0, 0, 0, 1, 3, 62));
        applyStimulus("overrun_sticky", 100, 1, 0, 0, 0, mk(0, 0, 0, 1, 3, 62));
        doClear("clear_error");

        // Skip.
        runSeq("skip_run", 5, 20);
        applyStimulus("skip", 22, 1, 0, 0, 0, mk(0, 0, 0, 1, 1, 15));
        applyStimulus("skip_sticky", 23, 1, 0, 0, 0, mk(0, 0, 0, 1, 1, 15));
        applyStimulus("skip_sticky", 5, 1, 0, 0, 0, mk(0, 0, 0, 1, 1, 15));
        doClear("clear_skip");

        // Stall reaching the limit.
        runSeq("stall_run", 5, 10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall_repeat", 10, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 5));
        end
        applyStimulus("stall_hit", 10, 1, 0, 0, 0, mk(0, 0, 0, 1, 2, 5));
        doClear("clear_stall");

        // Stall one short of the limit, then recovery.
        runSeq("nostall_run", 5, 10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("nostall_repeat", 10, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 5));
        end
        applyStimulus("nostall_step", 11, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 6));
        applyStimulus("nostall_step", 12, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 7));
        doClear("clear_run");

        // Overrun in RUN takes priority over skip.
        runSeq("ovr_run", 5, 30);
        applyStimulus("run_overrun", 200, 1, 0, 0, 0, mk(0, 0, 0, 1, 3, 25));
        doClear("clear_overrun");

        // Freeze: long hold with enable low must not count as a stall.
        runSeq("freeze_run", 5, 40);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("freeze_hold", 40, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 35));
        end
        applyStimulus("freeze_resume", 41, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 36));
        runSeq("freeze_cont", 42, 50);

        // Reset mid-run discards progress; restart needs a fresh START.
        applyStimulus("rst_mid_run", 50, 1, 0, 1, 0, IDLE0);
        applyStimulus("after_rst", 51, 1, 0, 0, 0, IDLE0);
        applyStimulus("after_rst", 6, 1, 0, 0, 0, IDLE0);
        applyStimulus("restart", 5, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0));
        applyStimulus("restart", 6, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 1));
        applyStimulus("clear_and_rst", 7, 1, 1, 1, 0, IDLE0);

        // START == STOP instance goes straight to DONE.
        applyStimulus("eq_reset", 0, 0, 0, 1, 1, IDLE0);
        applyStimulus("eq_idle", 8, 1, 0, 0, 1, IDLE0);
        applyStimulus("eq_done", 9, 1, 0, 0, 1, mk(0, 1, 1, 0, 0, 0));
        applyStimulus("eq_hold", 9, 1, 0, 0, 1, mk(0, 1, 0, 0, 0, 0));
        applyStimulus("eq_overrun", 10, 1, 0, 0, 1, mk(0, 0, 0, 1, 3, 0));
        applyStimulus("eq_clear", 0, 1, 1, 0, 1, IDLE0);

        @(negedge clk);
        enable = 1'b0;
        clear  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
